// File: rtl/dmem_wbuf_pkg.sv
// Shared types for the data-memory stage posted write buffer.
// Entry index is sized for the widest word address; unused upper bits stay zero.
package dmem_wbuf_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = $clog2(WORD_BYTES);
  localparam int IDX_MAX_W  = 32 - BYTE_W;

  typedef logic [IDX_MAX_W-1:0] wbuf_idx_t;

  typedef struct packed {
    wbuf_idx_t   index;
    logic [31:0] data;
  } wbuf_entry_t;

  typedef enum logic {
    IDLE,
    WRITING
  } drain_state_t;

  // Word index with address bits above the RAM range dropped.
  function automatic wbuf_idx_t word_index(
    input logic [31:0] addr,
    input int unsigned aw
  );
    wbuf_idx_t mask;
    mask = (wbuf_idx_t'(1) << aw) - wbuf_idx_t'(1);
    return addr[31:BYTE_W] & mask;
  endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Write-buffer FIFO: entry storage, head/tail/count and flags.
// All entries plus a valid mask are exposed for the load search.
module wbuf_fifo
  import dmem_wbuf_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  wbuf_entry_t              i_entry,
  output wbuf_entry_t [DEPTH-1:0]  o_entries,
  output logic        [DEPTH-1:0]  o_valid,
  output logic        [PTR_W-1:0]  o_head_ptr,
  output logic        [CNT_W-1:0]  o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  logic        [PTR_W-1:0] r_head;
  logic        [PTR_W-1:0] r_tail;
  logic        [CNT_W-1:0] r_count;
  wbuf_entry_t [DEPTH-1:0] r_mem;
  logic        [PTR_W-1:0] w_off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_tail] <= i_entry;
  end

  // Slot i is live when its distance from head is below count.
  always_comb begin
    o_valid = '0;
    w_off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off      = PTR_W'(i) - r_head;
      o_valid[i] = CNT_W'(w_off) < r_count;
    end
  end

  assign o_entries  = r_mem;
  assign o_head_ptr = r_head;
  assign o_count    = r_count;
  assign o_full     = r_count == CNT_W'(DEPTH);
  assign o_empty    = r_count == '0;

endmodule

// File: rtl/dmem_wbuf.sv
// Data-memory stage: posted write buffer draining into a word RAM.
// WBUF_FWD_EN enables store-to-load forwarding; otherwise matching loads stall.
module dmem_wbuf
  import dmem_wbuf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int WR_LAT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             ALUOutM,
  input  logic [31:0]             WriteDataM,
  input  logic                    MemWriteM,
  input  logic                    MemReadM,
  output logic [31:0]             DmmRD,
  output logic                    stall,
  output logic [$clog2(DEPTH):0]  wbuf_count,
  output logic                    wbuf_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(WR_LAT - 1);

  wbuf_idx_t               w_idx;
  wbuf_entry_t             w_new;
  wbuf_entry_t [DEPTH-1:0] w_entries;
  logic        [DEPTH-1:0] w_valid;
  logic        [PTR_W-1:0] w_head_ptr;
  logic        [PTR_W-1:0] w_slot;
  logic        [CNT_W-1:0] w_count;
  logic        [CNT_W-1:0] w_remain;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_match;
  logic        [31:0]      w_ram_rd;
  logic        [31:0]      w_rd;

  drain_state_t            r_state;
  drain_state_t            w_state_nx;
  logic        [LAT_W-1:0] r_lat;
  logic        [LAT_W-1:0] w_lat_nx;

  logic [31:0] r_ram [2**ADDR_W];

  assign w_idx  = word_index(ALUOutM, ADDR_W);
  assign w_new  = '{index: w_idx, data: WriteDataM};
  assign w_push = MemWriteM && !w_full;

  wbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_entry    (w_new),
    .o_entries  (w_entries),
    .o_valid    (w_valid),
    .o_head_ptr (w_head_ptr),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_lat   <= w_lat_nx;
    end
  end

  // Remaining entries after a pop include a same-edge enqueue.
  always_comb begin
    w_state_nx = r_state;
    w_lat_nx   = r_lat;
    w_pop      = 1'b0;
    w_remain   = w_count - CNT_W'(1) + CNT_W'(w_push);
    unique case (r_state)
      IDLE: begin
        if (w_count != '0) begin
          w_state_nx = WRITING;
          w_lat_nx   = LAT_RELOAD;
        end
      end
      WRITING: begin
        if (r_lat != '0) begin
          w_lat_nx = r_lat - 1'b1;
        end else begin
          w_pop = 1'b1;
          if (w_remain != '0) w_lat_nx   = LAT_RELOAD;
          else                w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_ram[w_entries[w_head_ptr].index[ADDR_W-1:0]]
        <= w_entries[w_head_ptr].data;
    end
  end

  assign w_ram_rd = r_ram[w_idx[ADDR_W-1:0]];

`ifdef WBUF_FWD_EN
  logic [31:0] w_fwd_data;

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    w_match    = 1'b0;
    w_fwd_data = '0;
    w_slot     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_slot = w_head_ptr + PTR_W'(k);
      if (w_valid[w_slot] && w_entries[w_slot].index == w_idx) begin
        w_match    = 1'b1;
        w_fwd_data = w_entries[w_slot].data;
      end
    end
  end

  assign w_rd  = w_match ? w_fwd_data : w_ram_rd;
  assign stall = MemWriteM && w_full;
`else
  always_comb begin
    w_match = 1'b0;
    w_slot  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_slot = w_head_ptr + PTR_W'(k);
      if (w_valid[w_slot] && w_entries[w_slot].index == w_idx) begin
        w_match = 1'b1;
      end
    end
  end

  assign w_rd  = w_ram_rd;
  assign stall = (MemWriteM && w_full) || (MemReadM && w_match);
`endif

  assign DmmRD      = reset ? '0 : w_rd;
  assign wbuf_count = w_count;
  assign wbuf_empty = w_empty;

endmodule

// File: doc/dmem_wbuf.md
Name: dmem_wbuf

Overview:
- Data-memory stage directly downstream of the pipelined core's memory stage.
- Consumes the core's ALU result address, store data and memory-write strobe. Returns load data.
- Stores pass through a small posted write buffer (FIFO) that drains into a word RAM with a fixed multi-cycle write latency.
- Loads read combinationally, with store-to-load forwarding from the buffer. A stall output is asserted when the buffer cannot accept a store.

Parameters:
- DEPTH, 4, write-buffer entries (power of 2, ≥2)
- ADDR_W, 8, word-address bits (RAM holds 2^ADDR_W 32-bit words)
- WR_LAT, 2, cycles the RAM needs per drained write (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ALUOutM  in  32  byte address from memory stage
- WriteDataM  in  32  store data
- MemWriteM  in  1  store request
- MemReadM  in  1  load request
- DmmRD  out  32  load data (combinational)
- stall  out  1  core must hold memory stage this cycle
- wbuf_count  out  $clog2(DEPTH)+1  valid entries
- wbuf_empty  out  1  no pending stores

Behaviour:
Reset (async, active-high):
- head, tail, count, drain FSM and latency counter cleared. FSM goes to IDLE.
- Outputs: stall=0, wbuf_count=0, wbuf_empty=1. DmmRD=0 while reset is high.
- RAM array is not reset.
- Reset mid-drain discards all pending entries; the in-flight write is not committed.

Addressing:
- word index = ALUOutM[ADDR_W+1:2]. Bits [1:0] are ignored. Bits above ADDR_W+1 are ignored (aliasing).

Enqueue:
- At posedge when MemWriteM && !full: entry {index, WriteDataM} is written at tail, and tail increments mod DEPTH.
- full = (count==DEPTH).
- stall = MemWriteM && full, combinational. The store is not accepted and the core re-presents it.
- No enqueue when full even if a drain completes the same edge. This keeps stall free of any dependency on drain timing.

Drain FSM:
- States IDLE and WRITING. lat_cnt is ceil-width counter.
- IDLE: if count>0 at posedge, go to WRITING with lat_cnt=WR_LAT-1.
- WRITING, lat_cnt≠0: decrement.
- WRITING, lat_cnt==0: RAM[head.index] <= head.data, head pops, count decrements.
  - Then, if entries remain (post-pop count including same-edge enqueue >0): stay WRITING and reload lat_cnt=WR_LAT-1.
  - Otherwise go to IDLE.
- Simultaneous enqueue and pop: count unchanged.
- Sustained throughput: one write per WR_LAT cycles, plus one IDLE cycle only after the buffer empties.

Loads (MemReadM=1):
- DmmRD = data of the youngest valid entry whose index matches. If no entry matches, DmmRD = RAM[index].
- The head entry remains forwardable until its pop edge.
- Loads never enqueue or alter state.
- MemReadM=0: DmmRD still presents the same lookup. The value is don't-care to the core but must be deterministic.
- MemWriteM and MemReadM both high: the store path acts as above. DmmRD reflects pre-edge state.

Pointer wrap:
- head and tail wrap mod DEPTH.
- count distinguishes full from empty.

Optional Feature:
Macro WBUF_FWD_EN.
- Defined: forwarding as above. Loads never stall.
- Undefined: no forwarding comparators.
  - A load (MemReadM) whose index matches any valid entry asserts stall until no valid entry matches.
  - DmmRD comes from RAM only.
  - stall = (MemWriteM && full) || (MemReadM && match).

Decomposition:
- Shared package holds:
  - wbuf entry struct {index[ADDR_W-1:0], data[31:0]}
  - drain-state enum {IDLE, WRITING}
  - WORD_BYTES=4 constant
- One natural sub-module: wbuf_fifo.
  - Contains storage, head/tail/count, and the full/empty flags.
  - Exposes all entries plus a valid mask for the forwarding search.
- The drain FSM, RAM and forwarding mux stay in dmem_wbuf.

Test Plan:
1. Reset mid-drain:
   - Stimulus: preload RAM[3]=0, store 0xAAAA0001 to byte addr 0x0C, assert reset one cycle later.
   - Required: count=0, wbuf_empty=1, RAM[3] still 0, stall=0.
2. Single store then load, WR_LAT=2:
   - Stimulus: store 0x12345678 to 0x10, load 0x10 the next cycle.
   - Required: DmmRD=0x12345678 via forwarding. RAM[4]=0x12345678 exactly 3 edges after the enqueue edge (1 IDLE + 2 WRITING). wbuf_empty returns to 1.
3. Youngest-match forwarding:
   - Stimulus: stores 0x1, 0x2, 0x3 to addr 0x20 back-to-back, then load 0x20.
   - Required: DmmRD=0x3. After drain, RAM[8]=0x3.
4. Full buffer, DEPTH=4, WR_LAT=4:
   - Stimulus: 6 consecutive stores to addrs 0x0,0x4,…,0x14.
   - Required: stall=1 on the 5th store until count<4. No store lost. All 6 RAM words correct. count never exceeds 4.
5. Wrap-around:
   - Stimulus: 3×DEPTH stores to distinct addresses, interleaved with random idle cycles.
   - Required: RAM contents match a reference model in order. head and tail wrap cleanly. Final count=0.
6. WBUF_FWD_EN undefined:
   - Stimulus: store 0xBEEF to 0x40, immediate load 0x40.
   - Required: stall=1 until the entry pops. Then DmmRD=0xBEEF from RAM and stall=0.
